// File: rtl/sseg_pkg.sv
// ------------------------------------------------------------------
// sseg_pkg: glyph table, blank pattern and FSM encoding shared by the
// seven-segment encoder/decoder and the scan capture block. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Active-low, bit0 = segment a .. bit6 = segment g; element n is hex digit n.
    localparam logic [15:0][6:0] c_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] c_BLANK = 7'h7F;

    function automatic logic [6:0] hex2_7seg(input logic [3:0] hex);
        return c_GLYPHS[hex];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sseg2hex.sv
// ------------------------------------------------------------------
// sseg2hex: combinational decode of an active-low 7-segment pattern
// back to its hex value, flagging patterns outside the glyph table. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sseg2hex
    import sseg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] hex_o,
    output logic       legal_o
);

    always_comb begin
        hex_o   = 4'h0;
        legal_o = 1'b0;
        // The blank pattern is absent from the table, so it decodes as illegal.
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == c_GLYPHS[i]) begin
                hex_o   = 4'(i);
                legal_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_capture.sv
// ------------------------------------------------------------------
// sseg_scan_capture: samples a multiplexed 4-digit 7-segment display
// bus and recovers the hex value shown on each digit. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic [6:0]  sseg,
    input  logic [3:0]  anode,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        seg_err
);

    localparam int              c_CW     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE_CYCLES);

    logic [6:0]      sseg_meta_q, sseg_sync_q;
    logic [3:0]      anode_meta_q, anode_sync_q;

    state_t          state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [3:0]      lat_anode_q, lat_anode_d;
    logic [6:0]      lat_sseg_q, lat_sseg_d;
    logic [1:0]      idx_q, idx_d;

    logic [15:0]     digits_q, digits_d;
    logic [3:0]      valid_q, valid_d;
    logic [3:0]      mask_q, mask_d;
    logic            frame_q, err_q, err_d;

    logic            w_onehot, w_changed, w_start, w_capture, w_legal;
    logic [1:0]      w_idx;
    logic [3:0]      w_hex;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            sseg_meta_q  <= '1;
            sseg_sync_q  <= '1;
            anode_meta_q <= '1;
            anode_sync_q <= '1;
        end else begin
            sseg_meta_q  <= sseg;
            sseg_sync_q  <= sseg_meta_q;
            anode_meta_q <= anode;
            anode_sync_q <= anode_meta_q;
        end
    end

    always_comb begin
        w_onehot = 1'b1;
        w_idx    = 2'd0;
        case (anode_sync_q)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    assign w_changed = (anode_sync_q != lat_anode_q) || (sseg_sync_q != lat_sseg_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_anode_d = lat_anode_q;
        lat_sseg_d  = lat_sseg_q;
        idx_d       = idx_q;
        w_start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_start = w_onehot;
            end
            ST_SETTLE, ST_HOLD: begin
                if (w_changed) begin
                    if (w_onehot) begin
                        w_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (state_q == ST_SETTLE && cnt_q != c_SETTLE) begin
                    cnt_d = cnt_q + c_CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (w_start) begin
            state_d     = ST_SETTLE;
            cnt_d       = c_CW'(1);
            lat_anode_d = anode_sync_q;
            lat_sseg_d  = sseg_sync_q;
            idx_d       = w_idx;
        end

        // Capture on the edge where the count reaches its target, then park in HOLD.
        w_capture = (state_d == ST_SETTLE) && (cnt_d == c_SETTLE);
        if (w_capture) begin
            state_d = ST_HOLD;
        end
    end

    sseg2hex u_sseg2hex (
        .pattern_i (lat_sseg_d),
        .hex_o     (w_hex),
        .legal_o   (w_legal)
    );

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        mask_d   = (mask_q == 4'hF) ? 4'h0 : mask_q;
        if (w_capture) begin
            if (w_legal) begin
                digits_d[4*idx_d +: 4] = w_hex;
                valid_d[idx_d]         = 1'b1;
                mask_d[idx_d]          = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_anode_q <= '1;
            lat_sseg_q  <= '1;
            idx_q       <= 2'd0;
            digits_q    <= 16'h0000;
            valid_q     <= 4'h0;
            mask_q      <= 4'h0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_anode_q <= lat_anode_d;
            lat_sseg_q  <= lat_sseg_d;
            idx_q       <= idx_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            frame_q     <= (mask_q == 4'hF);
            err_q       <= err_d;
        end
    end

    assign digits     = digits_q;
    assign valid      = valid_q;
    assign frame_done = frame_q;
    assign seg_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_capture.sv
// ------------------------------------------------------------------
// tb_sseg_scan_capture: directed scan scenarios checked against a
// run-length behavioural model every cycle, plus literal checkpoints. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_sseg_scan_capture;

    localparam int SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  sseg = 7'h7F;
    logic [3:0]  anode = 4'hF;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        frame_done, seg_err;

    int n_pass = 0, n_total = 0;
    int frames = 0, errs = 0;

    sseg_scan_capture #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_50MHz  (clk),
        .rst        (rst),
        .sseg       (sseg),
        .anode      (anode),
        .digits     (digits),
        .valid      (valid),
        .frame_done (frame_done),
        .seg_err    (seg_err)
    );

    always #10 clk = ~clk;

    function automatic logic [6:0] glyph(input int h);
        case (h)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: a digit is captured on the cycle its synchronized (anode, sseg)
    // pair has been one-hot and unchanged for exactly SETTLE consecutive edges.
    logic [10:0] m_s1 = '1, m_s2 = '1, m_prev = '1, m_x;
    int          m_run = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_valid = '0, m_mask = '0;
    logic        m_frame = 1'b0, m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_prev = '1; m_run = 0;
            m_digits = '0; m_valid = '0; m_mask = '0; m_frame = 1'b0; m_err = 1'b0;
        end else begin
            logic fr, legal, oh;
            int   idx, val;
            fr = (m_mask == 4'hF);
            if (fr) m_mask = 4'h0;
            m_x  = m_s2;
            m_s2 = m_s1;
            m_s1 = {anode, sseg};
            oh   = ($countones(~m_x[10:7]) == 1);
            if (m_x == m_prev && m_run > 0) m_run++;
            else m_run = oh ? 1 : 0;
            m_prev = m_x;
            m_err  = 1'b0;
            if (m_run == SETTLE) begin
                idx = 0; legal = 1'b0; val = 0;
                for (int b = 0; b < 4; b++) if (!m_x[7+b]) idx = b;
                for (int h = 0; h < 16; h++) if (glyph(h) == m_x[6:0]) begin legal = 1'b1; val = h; end
                if (legal) begin
                    m_digits[4*idx +: 4] = 4'(val);
                    m_valid[idx] = 1'b1;
                    m_mask[idx]  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_frame = fr;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model", {10'd0, digits, valid, frame_done, seg_err},
                           {10'd0, m_digits, m_valid, m_frame, m_err});
            if (frame_done) frames++;
            if (seg_err) errs++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] scan_vals [4];
        scan_vals = '{4'hA, 4'h5, 4'h0, 4'hF};

        step(2);
        check("reset_outputs", {10'd0, digits, valid, frame_done, seg_err}, 32'd0);
        rst = 1'b0;

        // Single digit: capture lands exactly 2 + SETTLE edges after the drive.
        anode = 4'b1110; sseg = glyph(3);
        step(17);
        check("d0_before_latency", {digits[3:0], valid}, {4'h0, 4'b0000});
        step(1);
        check("d0_at_latency", {digits[3:0], valid}, {4'h3, 4'b0001});
        step(2);
        check("d0_no_pulses", {frames[15:0], errs[15:0]}, 32'd0);

        // Full scan A,5,0,F across anodes 0..3.
        frames = 0;
        for (int i = 0; i < 4; i++) begin
            anode = ~(4'b0001 << i);
            sseg  = glyph(int'(scan_vals[i]));
            step(20);
        end
        check("scan_digits", digits, 32'hF05A);
        check("scan_valid", valid, 32'hF);
        check("scan_frames", frames, 1);

        // Pattern changing faster than the settle window never captures.
        frames = 0; errs = 0;
        anode = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            sseg = (k % 2 == 0) ? glyph(1) : glyph(7);
            step(10);
        end
        check("toggle_digits", digits, 32'hF05A);
        check("toggle_valid", valid, 32'hF);

        // Blank pattern settles: error pulse only.
        anode = 4'b1011; sseg = 7'h7F;
        step(20);
        check("blank_errs", errs, 1);
        check("blank_digit2", digits[11:8], 32'h0);
        check("blank_valid", valid, 32'hF);

        // Not one-hot anodes never capture.
        errs = 0;
        anode = 4'b1100; sseg = glyph(8);
        step(30);
        anode = 4'b1111;
        step(30);
        check("nonhot_digits", digits, 32'hF05A);
        check("nonhot_pulses", {frames[15:0], errs[15:0]}, 32'd0);

        // Asynchronous reset partway through a settle window.
        anode = 4'b1101; sseg = glyph(9);
        step(12);
        #2 rst = 1'b1;
        #1 check("async_reset", {10'd0, digits, valid, frame_done, seg_err}, 32'd0);
        step(2);
        rst = 1'b0;
        step(17);
        check("post_reset_wait", {digits, valid}, {16'h0000, 4'b0000});
        step(1);
        check("post_reset_capture", {digits, valid}, {16'h0090, 4'b0010});
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
